// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Holds the program counter (PC) and instruction register (IR) of the basic
// processor. It sits directly upstream of the control decoder.
//   - The IR loads from memory on load_IR. It presents op to the decoder and
//     operand to the datapath.
//   - The PC advances or branches on load_PC:
//       INC_PC = 1 : increment the PC.
//       INC_PC = 0 : branch to the operand.
//   - mem_addr selects the shared memory address: pc while fetching, operand
//     otherwise.
//   - retired counts completed instructions and saturates at its maximum.
//   - halted is a sticky flag. It is set when a taken branch targets its own
//     address (branch-to-self).
//
// Optional feature, macro BRANCH_TRACE_EN:
//   Adds a 4-entry branch-history FIFO of {source pc, target} pairs.
//   When the FIFO is full and a branch is taken with no pop, the oldest entry
//   is overwritten and trace_ovf is set; trace_ovf stays set until reset.
//
// Ports:
//   clock, n_reset          rising-edge clock, asynchronous active-low reset
//   load_IR, load_PC,       strobes from the decoder
//     INC_PC
//   instr_data[WORD_W]      memory read data
//   op[OP_W]                IR opcode field
//   operand[ADDR_W]         IR address/immediate field
//   pc[ADDR_W]              current PC
//   mem_addr[ADDR_W]        memory address (combinational)
//   retired[CNT_W]          retired-instruction count (saturating)
//   halted                  sticky branch-to-self flag
//   trace_pop / trace_valid / trace_from / trace_to / trace_ovf
//                           branch trace, present only with BRANCH_TRACE_EN
//
// WORD_W must equal OP_W + ADDR_W.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int OP_W   = 3,
    parameter int ADDR_W = 5,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              load_IR,
    input  logic              load_PC,
    input  logic              INC_PC,
    input  logic [WORD_W-1:0] instr_data,
    output logic [OP_W-1:0]   op,
    output logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CNT_W-1:0]  retired,
    output logic              halted
`ifdef BRANCH_TRACE_EN
    ,
    input  logic              trace_pop,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_from,
    output logic [ADDR_W-1:0] trace_to,
    output logic              trace_ovf
`endif
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [WORD_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              halted_q, halted_d;
    logic              branch_s;
    logic [ADDR_W-1:0] operand_s;

    assign operand_s = ir_q[ADDR_W-1:0];
    assign branch_s  = load_PC & ~INC_PC;

    // Next-state logic for IR, PC, retired counter and halt flag.
    // The IR and PC updates are independent, so a (nominally illegal)
    // cycle with both load_IR and load_PC high performs both updates.
    always_comb begin
        ir_d      = ir_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        halted_d  = halted_q;

        if (load_IR) begin
            ir_d = instr_data;
        end else begin
            ir_d = ir_q;
        end

        if (load_PC && INC_PC) begin
            pc_d = pc_q + ADDR_ONE;
        end else if (branch_s) begin
            pc_d = operand_s;
        end else begin
            pc_d = pc_q;
        end

        if (load_PC && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_ONE;
        end else begin
            retired_d = retired_q;
        end

        // The branch-to-self compare uses the pre-update PC.
        if (branch_s && (operand_s == pc_q)) begin
            halted_d = 1'b1;
        end else begin
            halted_d = halted_q;
        end
    end

    // Core state registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            ir_q      <= {WORD_W{1'b0}};
            pc_q      <= {ADDR_W{1'b0}};
            retired_q <= {CNT_W{1'b0}};
            halted_q  <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    assign op       = ir_q[WORD_W-1 -: OP_W];
    assign operand  = operand_s;
    assign pc       = pc_q;
    assign retired  = retired_q;
    assign halted   = halted_q;
    assign mem_addr = load_IR ? pc_q : operand_s;

`ifdef BRANCH_TRACE_EN
    logic [ADDR_W-1:0] tfrom_q [4];
    logic [ADDR_W-1:0] tto_q   [4];
    logic [1:0]        head_q, head_d;
    logic [1:0]        tail_q, tail_d;
    logic [2:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              pop_s;
    logic              full_s;

    // A pop request on an empty FIFO is ignored.
    assign pop_s  = trace_pop & (count_q != 3'd0);
    assign full_s = (count_q == 3'd4);

    // FIFO pointer, occupancy and overflow next-state logic.
    // When the FIFO is full, the write slot (tail) coincides with head.
    // A push while full therefore replaces the oldest entry, and head must
    // advance with it. This is the same pointer motion as pop-then-push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (branch_s) begin
            tail_d = tail_q + 2'd1;
            if (pop_s || full_s) begin
                head_d  = head_q + 2'd1;
                count_d = count_q;
            end else begin
                head_d  = head_q;
                count_d = count_q + 3'd1;
            end
            if (full_s && !pop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end else if (pop_s) begin
            head_d  = head_q + 2'd1;
            count_d = count_q - 3'd1;
        end else begin
            head_d  = head_q;
            count_d = count_q;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage, written at tail on every taken branch.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) begin
                tfrom_q[i] <= {ADDR_W{1'b0}};
                tto_q[i]   <= {ADDR_W{1'b0}};
            end
        end else if (branch_s) begin
            tfrom_q[tail_q] <= pc_q;
            tto_q[tail_q]   <= operand_s;
        end
    end

    assign trace_valid = (count_q != 3'd0);
    assign trace_from  = tfrom_q[head_q];
    assign trace_to    = tto_q[head_q];
    assign trace_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Stages:
//   - directed vector table
//   - halt-persistence sequence
//   - randomized run against a behavioural model
//   - counter saturation
//   - asynchronous reset in the middle of execute
//   - branch trace FIFO (BRANCH_TRACE_EN builds only)
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       load_IR = 1'b0;
    logic       load_PC = 1'b0;
    logic       INC_PC = 1'b0;
    logic [7:0] instr_data = 8'h00;
    logic [2:0] op;
    logic [4:0] operand, pc, mem_addr;
    logic [15:0] retired;
    logic       halted;
`ifdef BRANCH_TRACE_EN
    logic       trace_pop = 1'b0;
    logic       trace_valid, trace_ovf;
    logic [4:0] trace_from, trace_to;
`endif

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clock(clock), .n_reset(n_reset), .load_IR(load_IR), .load_PC(load_PC),
        .INC_PC(INC_PC), .instr_data(instr_data), .op(op), .operand(operand),
        .pc(pc), .mem_addr(mem_addr), .retired(retired), .halted(halted)
`ifdef BRANCH_TRACE_EN
        , .trace_pop(trace_pop), .trace_valid(trace_valid), .trace_from(trace_from),
        .trace_to(trace_to), .trace_ovf(trace_ovf)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of strobes; ma samples mem_addr just before the edge.
    // Returns at posedge+1 with the strobes cleared.
    task automatic step(input logic li, input logic lp, input logic inc,
                        input logic [7:0] d, output logic [4:0] ma);
        load_IR = li; load_PC = lp; INC_PC = inc; instr_data = d;
        #1 ma = mem_addr;
        @(posedge clock);
        #1;
        load_IR = 1'b0; load_PC = 1'b0; INC_PC = 1'b0;
    endtask

    task automatic do_reset();
        load_IR = 1'b0; load_PC = 1'b0; INC_PC = 1'b0;
        @(negedge clock);
        n_reset = 1'b0;
        @(negedge clock);
        n_reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       li, lp, inc;
        logic [7:0] d;
        logic [4:0] maddr, pc;
        logic [2:0] op;
        logic [4:0] opd;
        logic [15:0] ret;
        logic       h;
    } vec_t;

    vec_t tbl[16];

    // behavioural model state for the random run
    int         m_pc, m_ret;
    logic [7:0] m_ir;
    logic       m_h;
`ifdef BRANCH_TRACE_EN
    logic [9:0] m_tq[$];
    logic       m_ovf;
`endif

    initial begin
        logic [4:0] ma;
        int opd;

        //            li    lp    inc   data   maddr  pc     op    opd    ret     h
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'hA7, 5'd0,  5'd0,  3'd5, 5'd7,  16'd0,  1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd7,  5'd7,  3'd5, 5'd7,  16'd1,  1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h05, 5'd7,  5'd7,  3'd0, 5'd5,  16'd1,  1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd5,  5'd5,  3'd0, 5'd5,  16'd2,  1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd5,  5'd6,  3'd0, 5'd5,  16'd3,  1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h1F, 5'd6,  5'd6,  3'd0, 5'd31, 16'd3,  1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd31, 5'd31, 3'd0, 5'd31, 16'd4,  1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd31, 5'd0,  3'd0, 5'd31, 16'd5,  1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd31, 5'd0,  3'd0, 5'd31, 16'd5,  1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h69, 5'd0,  5'd1,  3'd3, 5'd9,  16'd6,  1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd9,  5'd9,  3'd3, 5'd9,  16'd7,  1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h43, 5'd9,  5'd9,  3'd2, 5'd3,  16'd7,  1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd3,  5'd3,  3'd2, 5'd3,  16'd8,  1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'hE4, 5'd3,  5'd3,  3'd7, 5'd4,  16'd8,  1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd4,  5'd4,  3'd7, 5'd4,  16'd9,  1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd4,  5'd4,  3'd7, 5'd4,  16'd10, 1'b1};

        // ---------------- reset state
        do_reset();
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_op", 32'(op), 32'd0);
        chk("reset_operand", 32'(operand), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);

        // ---------------- directed table
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].li, tbl[i].lp, tbl[i].inc, tbl[i].d, ma);
            chk($sformatf("tbl%0d_mem_addr", i), 32'(ma), 32'(tbl[i].maddr));
            chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_op", i), 32'(op), 32'(tbl[i].op));
            chk($sformatf("tbl%0d_operand", i), 32'(operand), 32'(tbl[i].opd));
            chk($sformatf("tbl%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
            chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].h));
        end

        // ---------------- halted remains set over the next 10 instructions
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, ma);
            step(1'b0, 1'b1, 1'b1, 8'h00, ma);
            chk($sformatf("halt_sticky%0d", i), 32'(halted), 32'd1);
            chk($sformatf("halt_pc%0d", i), 32'(pc), 32'(5 + i));
            chk($sformatf("halt_retired%0d", i), 32'(retired), 32'(11 + i));
        end

        // ---------------- randomized run vs. behavioural model
        do_reset();
        m_pc = 0; m_ret = 0; m_ir = 8'h00; m_h = 1'b0;
`ifdef BRANCH_TRACE_EN
        m_tq.delete(); m_ovf = 1'b0;
`endif
        for (int i = 0; i < 2000; i++) begin
            logic li, lp, inc, pop;
            logic [7:0] d;
            li  = 1'($urandom_range(0, 1));
            lp  = 1'($urandom_range(0, 1));
            inc = 1'($urandom_range(0, 2) != 0);
            pop = 1'($urandom_range(0, 3) == 0);
            d   = 8'($urandom);
            // steer some branches to land on the current pc
            if ($urandom_range(0, 7) == 0) d[4:0] = 5'(m_pc);
`ifdef BRANCH_TRACE_EN
            trace_pop = pop;
`endif
            step(li, lp, inc, d, ma);
`ifdef BRANCH_TRACE_EN
            trace_pop = 1'b0;
`endif
            chk("rnd_mem_addr", 32'(ma), li ? 32'(m_pc) : 32'(m_ir[4:0]));
            opd = int'(m_ir[4:0]);
`ifdef BRANCH_TRACE_EN
            if (lp && !inc) begin
                if (pop && m_tq.size() > 0) void'(m_tq.pop_front());
                else if (m_tq.size() == 4) begin
                    void'(m_tq.pop_front());
                    m_ovf = 1'b1;
                end
                m_tq.push_back({5'(m_pc), 5'(opd)});
            end else if (pop && m_tq.size() > 0) begin
                void'(m_tq.pop_front());
            end
`endif
            if (lp) begin
                if (m_ret < 65535) m_ret = m_ret + 1;
                if (inc) m_pc = (m_pc + 1) % 32;
                else begin
                    if (opd == m_pc) m_h = 1'b1;
                    m_pc = opd;
                end
            end
            if (li) m_ir = d;
            chk("rnd_pc", 32'(pc), 32'(m_pc));
            chk("rnd_op", 32'(op), 32'(m_ir[7:5]));
            chk("rnd_operand", 32'(operand), 32'(m_ir[4:0]));
            chk("rnd_retired", 32'(retired), 32'(m_ret));
            chk("rnd_halted", 32'(halted), 32'(m_h));
`ifdef BRANCH_TRACE_EN
            chk("rnd_trace_valid", 32'(trace_valid), 32'(m_tq.size() > 0));
            chk("rnd_trace_ovf", 32'(trace_ovf), 32'(m_ovf));
            if (m_tq.size() > 0) begin
                chk("rnd_trace_from", 32'(trace_from), 32'(m_tq[0][9:5]));
                chk("rnd_trace_to", 32'(trace_to), 32'(m_tq[0][4:0]));
            end
`endif
        end

        // ---------------- retired saturation
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'h00, ma);
            if (i == 65533) chk("sat_below_max", 32'(retired), 32'hFFFE);
        end
        chk("sat_at_max", 32'(retired), 32'hFFFF);
        step(1'b0, 1'b1, 1'b1, 8'h00, ma);
        chk("sat_hold", 32'(retired), 32'hFFFF);
        chk("sat_pc_wrap", 32'(pc), 32'd0);

        // ---------------- async reset in the middle of execute
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h0C, ma);
        step(1'b0, 1'b1, 1'b0, 8'h00, ma);
        step(1'b0, 1'b1, 1'b0, 8'h00, ma);      // branch-to-self at 12
        step(1'b1, 1'b0, 1'b0, 8'hAC, ma);
        chk("mid_pre_pc", 32'(pc), 32'd12);
        chk("mid_pre_halted", 32'(halted), 32'd1);
        load_PC = 1'b1; INC_PC = 1'b1;
        #2 n_reset = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_op", 32'(op), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd0);
        load_PC = 1'b0; INC_PC = 1'b0;
        @(negedge clock);
        n_reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_post_pc", 32'(pc), 32'd0);

`ifdef BRANCH_TRACE_EN
        // ---------------- trace FIFO overflow and drain
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'h00, ma);      // pc = 1
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, {3'b000, 5'(10 + k)}, ma);
            step(1'b0, 1'b1, 1'b0, 8'h00, ma);  // branch (1+k) -> (10+k)
            if (k == 3) chk("trace_no_ovf_at_4", 32'(trace_ovf), 32'd0);
            if (k < 4) begin
                for (int j = 0; j < 24; j++) step(1'b0, 1'b1, 1'b1, 8'h00, ma);
            end
        end
        chk("trace_ovf", 32'(trace_ovf), 32'd1);
        chk("trace_valid_full", 32'(trace_valid), 32'd1);
        chk("trace_head_from", 32'(trace_from), 32'd2);
        chk("trace_head_to", 32'(trace_to), 32'd11);
        for (int j = 0; j < 4; j++) begin
            trace_pop = 1'b1;
            step(1'b0, 1'b0, 1'b0, 8'h00, ma);
            trace_pop = 1'b0;
            if (j < 3) begin
                chk("trace_pop_from", 32'(trace_from), 32'(3 + j));
                chk("trace_pop_to", 32'(trace_to), 32'(12 + j));
                chk("trace_pop_valid", 32'(trace_valid), 32'd1);
            end else begin
                chk("trace_empty", 32'(trace_valid), 32'd0);
            end
        end
        trace_pop = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, ma);
        trace_pop = 1'b0;
        chk("trace_pop_empty_valid", 32'(trace_valid), 32'd0);
        chk("trace_pop_empty_ovf", 32'(trace_ovf), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
